// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM state, fetch entry and the default halt word.
// Pure declarations; no latency and no backpressure of its own.
package ifetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'h0000_000C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry fetch buffer; head comes straight from flops, zeroed when empty; push lands on the next edge.
// A push when full is dropped unless a pop happens in the same cycle; flush empties it and wins over both.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_dat,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // At full with a pop, the write reuses the head slot; the head is read from mem_q this cycle.
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, one fetch per cycle into a DEPTH buffer, start->first entry valid after 2 edges.
// Stalls with PC held while the buffer is full and not popping; IFETCH_STATS_EN adds fetch/flush counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC   = 32'h0000_0000,
  parameter int                 MEM_WORDS  = 256,
  parameter int                 DEPTH      = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ifq_valid,
  output logic [INSTR_W-1:0] ifq_instr,
  output logic [PC_W-1:0]    ifq_pc,
  input  logic               ifq_ready,
  output logic               halted,
  output logic               fault
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            fetch_oob, do_push, do_pop, halt_word;
  fetch_entry_t    push_dat, head_dat;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Redirect outranks everything; the halt word is queued but the PC stays on it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      state_d = ST_FETCH;
      pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_FETCH;
        ST_FETCH: begin
          if (fetch_oob) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else if (do_push) begin
            if (halt_word) state_d = ST_HALT;
            else           pc_d    = pc_q + 32'd4;
          end
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fetch_oob = ({2'b00, pc_q[PC_W-1:2]} >= 32'(MEM_WORDS));
    halt_word = (imem_data == HALT_INSTR);
    do_pop    = !fifo_empty && ifq_ready && !redirect_valid;
    do_push   = (state_q == ST_FETCH) && !redirect_valid && !fetch_oob &&
                ((fifo_count < CNT_W'(DEPTH)) || do_pop);
    push_dat  = '{pc: pc_q, instr: imem_data};
    imem_addr = {2'b00, pc_q[PC_W-1:2]};
    halted    = (state_q == ST_HALT);
    fault     = fault_q;
    ifq_valid = !fifo_empty;
    ifq_pc    = head_dat.pc;
    ifq_instr = head_dat.instr;
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (do_push),
    .push_dat (push_dat),
    .pop      (do_pop),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic [32:0] flush_sum;

  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_flushed_d = stat_flushed_q;
    flush_sum      = {1'b0, stat_flushed_q} + 33'(fifo_count);
    if (state_q != ST_IDLE) begin
      if (do_push && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
      if (redirect_valid) stat_flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a default instance plus one placed near the top of instruction memory.
// Expected {pc, instr} pairs are queued from the bench memory image and compared on every decode pop.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifq_ready = 1'b0;
  logic        f_ready = 1'b1;

  logic [31:0] imem_addr, imem_data, ifq_instr, ifq_pc;
  logic        ifq_valid, halted, fault;
  logic [31:0] f_imem_addr, f_imem_data, f_instr, f_pc;
  logic        f_valid, f_halted, f_fault;

  logic [31:0] mem [256];
  logic [63:0] sb [$];
  logic [63:0] sb_f [$];

  int n_tests = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int f_pop_cnt = 0;
  int cyc = 0;
  bit f_mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_data   = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'h0;
  assign f_imem_data = (f_imem_addr < 32'd256) ? mem[f_imem_addr[7:0]] : 32'h0;

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifq_valid(ifq_valid), .ifq_instr(ifq_instr), .ifq_pc(ifq_pc), .ifq_ready(ifq_ready),
    .halted(halted), .fault(fault)
  );

  ifetch_ctrl #(.RESET_PC(32'h0000_03F8), .MEM_WORDS(256)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(f_imem_addr), .imem_data(f_imem_data),
    .ifq_valid(f_valid), .ifq_instr(f_instr), .ifq_pc(f_pc), .ifq_ready(f_ready),
    .halted(f_halted), .fault(f_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void exp_push(input logic [31:0] pc);
    sb.push_back({pc, mem[pc[9:2]]});
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && ifq_valid && ifq_ready && !redirect_valid) begin
      pop_cnt++;
      chk("sb_has_exp", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", ifq_pc, e[63:32]);
        chk("pop_instr", ifq_instr, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (f_mon_en && rst_n && f_valid && f_ready) begin
      f_pop_cnt++;
      chk("f_sb_has_exp", 32'(sb_f.size() != 0), 32'd1);
      if (sb_f.size() != 0) begin
        e = sb_f.pop_front();
        chk("f_pop_pc", f_pc, e[63:32]);
        chk("f_pop_instr", f_instr, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    ifq_ready = 1'b0;
    f_mon_en = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    sb_f.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget, output int at_cyc);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(pop_cnt >= target), 32'd1);
    at_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c1, c3, c4, n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // Reset state, then IDLE must hold without start
    do_reset();
    chk("rst_valid", {31'b0, ifq_valid}, 32'd0);
    chk("rst_instr", ifq_instr, 32'd0);
    chk("rst_pc", ifq_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_f_addr", f_imem_addr, 32'h0FE);
    repeat (3) tick();
    chk("idle_valid", {31'b0, ifq_valid}, 32'd0);

    // Test 1: streaming with ready high
    base = pop_cnt;
    ifq_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_push(32'(k * 4));
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t1_valid_after_N", {31'b0, ifq_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_valid_after_N1", {31'b0, ifq_valid}, 32'd1);
    chk("t1_first_pc", ifq_pc, 32'h0);
    chk("t1_first_instr", ifq_instr, 32'h11);
    tick();
    c1 = cyc;
    wait_pops("t1_pops", base + 4, 12, c4);
    chk("t1_back_to_back", 32'(c4 - c1), 32'd3);
    ifq_ready = 1'b0;
    chk("t1_sb_left", 32'(sb.size()), 32'd4);

    // Test 2: backpressure, then release with no bubble
    do_reset();
    base = pop_cnt;
    for (int k = 0; k < 8; k++) exp_push(32'(k * 4));
    pulse_start();
    repeat (5) tick();
    chk("t2_no_pop", 32'(pop_cnt - base), 32'd0);
    chk("t2_valid", {31'b0, ifq_valid}, 32'd1);
    chk("t2_head_pc", ifq_pc, 32'h0);
    chk("t2_stall_addr", imem_addr, 32'd2);
    ifq_ready = 1'b1;
    wait_pops("t2_pop1", base + 1, 10, c1);
    wait_pops("t2_pop3", base + 3, 10, c3);
    chk("t2_no_gap", 32'(c3 - c1), 32'd2);
    ifq_ready = 1'b0;
    repeat (3) tick();
    chk("t2_refill_addr", imem_addr, 32'd5);
    chk("t2_refill_head", ifq_pc, 32'h0C);

    // Test 3: redirect with full buffer and a same-cycle pop
    base = pop_cnt;
    sb.delete();
    for (int k = 0; k < 8; k++) exp_push(32'h40 + 32'(k * 4));
    ifq_ready = 1'b1;
    do_redirect(32'h41);
    ifq_ready = 1'b0;
    @(negedge clk);
    chk("t3_flushed_valid", {31'b0, ifq_valid}, 32'd0);
    chk("t3_flushed_pc", ifq_pc, 32'd0);
    chk("t3_redirect_pop_dropped", 32'(pop_cnt - base), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_new_valid", {31'b0, ifq_valid}, 32'd1);
    chk("t3_new_pc", ifq_pc, 32'h40);
    chk("t3_new_instr", ifq_instr, mem[16]);
    tick();
    ifq_ready = 1'b1;
    wait_pops("t3_pops", base + 2, 10, c1);
    ifq_ready = 1'b0;

    // Test 4: halt word at pc 8
    mem[2] = 32'h0000_000C;
    do_reset();
    base = pop_cnt;
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    ifq_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    chk("t4_halted", {31'b0, halted}, 32'd1);
    repeat (4) tick();
    chk("t4_pops", 32'(pop_cnt - base), 32'd3);
    chk("t4_pc_hold", imem_addr, 32'd2);
    chk("t4_drained", {31'b0, ifq_valid}, 32'd0);
    pulse_start();
    repeat (3) tick();
    chk("t4_start_ignored", {31'b0, halted}, 32'd1);
    chk("t4_start_no_fetch", 32'(pop_cnt - base), 32'd3);
    exp_push(32'h10); exp_push(32'h14);
    do_redirect(32'h10);
    wait_pops("t4_resume", base + 5, 10, c1);
    chk("t4_resumed", {31'b0, halted}, 32'd0);
    ifq_ready = 1'b0;
    mem[2] = 32'h33;

    // Test 5: fetch runs off the end of instruction memory
    do_reset();
    f_mon_en = 1'b1;
    base = f_pop_cnt;
    sb_f.push_back({32'h3F8, mem[254]});
    sb_f.push_back({32'h3FC, mem[255]});
    pulse_start();
    repeat (8) tick();
    chk("t5_pushes", 32'(f_pop_cnt - base), 32'd2);
    chk("t5_fault", {31'b0, f_fault}, 32'd1);
    chk("t5_halted", {31'b0, f_halted}, 32'd1);
    chk("t5_pc_hold", f_imem_addr, 32'h100);
    chk("t5_main_no_fault", {31'b0, fault}, 32'd0);
    f_mon_en = 1'b0;
    repeat (3) tick();
    chk("t5_fault_sticky", {31'b0, f_fault}, 32'd1);

    // Test 6: asynchronous reset mid-stream with the buffer full
    do_reset();
    pulse_start();
    repeat (4) tick();
    chk("t6_full_valid", {31'b0, ifq_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, ifq_valid}, 32'd0);
    chk("t6_async_pc", imem_addr, 32'd0);
    chk("t6_async_instr", ifq_instr, 32'd0);
    chk("t6_async_fault_clr", {31'b0, f_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_idle_valid", {31'b0, ifq_valid}, 32'd0);
    chk("t6_idle_addr", imem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
